// File: rtl/dbus_req_buffer_if.sv
// Data-bus request buffer interface and shared types.
//
// dbus_pkg      : request/response structs and access-size encoding.
// dbus_req_buffer_if : bundles every handshake/bus signal of the buffer.
//   ureq     memory stage -> buffer   request (valid, addr, size, strobe, data)
//   uresp    buffer -> memory stage   response (addr_ok, data_ok, data)
//   misalign buffer -> memory stage   qualifies uresp.data_ok: misaligned access
//   timeout  buffer -> memory stage   qualifies uresp.data_ok: bus timeout
//   dreq     buffer -> cache/bus      registered request
//   dresp    cache/bus -> buffer      bus response
//   busy     buffer -> memory stage   buffer is not idle
//
// Handshake: a request is offered by holding ureq.valid; the buffer takes it
// in the cycle it is idle and flush is low. dreq is valid from the cycle
// after acceptance until (and including) the cycle dresp.data_ok is seen,
// and its fields do not change during that window. dresp.addr_ok accepts
// the address, dresp.data_ok completes the transfer. uresp.data_ok is a
// one-cycle completion pulse; misalign/timeout only mean something while
// it is high.
package dbus_pkg;
  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
endpackage

interface dbus_req_buffer_if;
  import dbus_pkg::*;

  dbus_req_t  ureq;
  dbus_resp_t uresp;
  logic       misalign;
  logic       timeout;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  logic       busy;

  // slave: the buffer itself
  modport slave (
    input  ureq, dresp,
    output uresp, misalign, timeout, dreq, busy
  );

  // master: memory stage plus cache/bus surrounding the buffer
  modport master (
    output ureq, dresp,
    input  uresp, misalign, timeout, dreq, busy
  );
endinterface

// File: rtl/dbus_req_buffer.sv
// Registered request buffer between the memory stage and the data cache/bus.
// Captures one request, holds it stable on the bus until data_ok, and
// returns the response combinationally. A flush keeps an in-flight bus
// transfer alive (DRAIN) but drops its response. Misaligned requests are
// answered locally; bus waits are bounded by TIMEOUT cycles (0 = no limit).
//
// Ports:
//   clk          clock, all state on posedge
//   reset        asynchronous active-low reset
//   flush        pipeline flush
//   io_bus       dbus_req_buffer_if.slave (ureq/uresp/misalign/timeout/
//                dreq/dresp/busy)
//   o_dbg_state  current FSM state (debug visibility)
module dbus_req_buffer
  import dbus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  dbus_req_buffer_if.slave   io_bus,
  output logic [2:0]         o_dbg_state
);

  localparam int          CW       = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit          TO_EN    = (TIMEOUT != 0);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_DATA = 3'd2,
    S_DRAIN     = 3'd3,
    S_ERR       = 3'd4
  } state_t;

  state_t     r_state;
  state_t     w_next;
  dbus_req_t  r_dreq;
  logic [CW-1:0] r_cnt;

  logic       w_load;
  logic       w_done;
  logic       w_misaligned;
  logic       w_timeout_hit;
  dbus_resp_t w_uresp;
  logic       w_misalign;
  logic       w_timeout;

  always_comb begin
    w_misaligned = 1'b0;
    case (io_bus.ureq.size)
      MSIZE2:  w_misaligned = io_bus.ureq.addr[0];
      MSIZE4:  w_misaligned = |io_bus.ureq.addr[1:0];
      MSIZE8:  w_misaligned = |io_bus.ureq.addr[2:0];
      default: w_misaligned = 1'b0;
    endcase
  end

  // Counter reads 0 in the first ISSUE cycle, so CNT_LAST marks the
  // TIMEOUT-th bus-wait cycle.
  assign w_timeout_hit = TO_EN && (r_cnt == CNT_LAST);

  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_done     = 1'b0;
    w_uresp    = '0;
    w_misalign = 1'b0;
    w_timeout  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (io_bus.ureq.valid && !flush) begin
          if (w_misaligned) begin
            w_next = S_ERR;
          end else begin
            w_load = 1'b1;
            w_next = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        w_uresp.addr_ok = io_bus.dresp.addr_ok;
        // Flush loses to a completion that is already here; the response is
        // simply not forwarded. Flush wins over timeout.
        if (io_bus.dresp.addr_ok && io_bus.dresp.data_ok) begin
          w_done = 1'b1;
          w_next = S_IDLE;
          if (!flush) begin
            w_uresp.data_ok = 1'b1;
            w_uresp.data    = io_bus.dresp.data;
          end
        end else if (flush) begin
          w_next = S_DRAIN;
        end else if (w_timeout_hit) begin
          w_uresp.data_ok = 1'b1;
          w_timeout       = 1'b1;
          w_next          = S_DRAIN;
        end else if (io_bus.dresp.addr_ok) begin
          w_next = S_WAIT_DATA;
        end
      end

      S_WAIT_DATA: begin
        if (io_bus.dresp.data_ok) begin
          w_done = 1'b1;
          w_next = S_IDLE;
          if (!flush) begin
            w_uresp.data_ok = 1'b1;
            w_uresp.data    = io_bus.dresp.data;
          end
        end else if (flush) begin
          w_next = S_DRAIN;
        end else if (w_timeout_hit) begin
          w_uresp.data_ok = 1'b1;
          w_timeout       = 1'b1;
          w_next          = S_DRAIN;
        end
      end

      // Bus is still owed its completion; nothing goes upstream.
      S_DRAIN: begin
        if (io_bus.dresp.data_ok) begin
          w_done = 1'b1;
          w_next = S_IDLE;
        end
      end

      S_ERR: begin
        w_uresp.data_ok = 1'b1;
        w_misalign      = 1'b1;
        w_next          = S_IDLE;
      end

      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dreq <= '0;
    end else if (w_load) begin
      r_dreq <= '{valid:  1'b1,
                  addr:   io_bus.ureq.addr,
                  size:   io_bus.ureq.size,
                  strobe: io_bus.ureq.strobe,
                  data:   io_bus.ureq.data};
    end else if (w_done) begin
      r_dreq.valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_load) begin
      r_cnt <= '0;
    end else if (((r_state == S_ISSUE) || (r_state == S_WAIT_DATA)) && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign io_bus.dreq     = r_dreq;
  assign io_bus.uresp    = w_uresp;
  assign io_bus.misalign = w_misalign;
  assign io_bus.timeout  = w_timeout;
  assign io_bus.busy     = (r_state != S_IDLE);
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_dbus_req_buffer.sv
module tb_dbus_req_buffer;
  import dbus_pkg::*;

  localparam int unsigned T = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       flush = 1'b0;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  dbus_req_buffer_if bus();

  dbus_req_buffer #(.TIMEOUT(T)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .io_bus      (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_misaligned(input logic [63:0] a, input msize_t s);
    case (s)
      MSIZE2:  return a[0];
      MSIZE4:  return a[1:0] != 2'b00;
      MSIZE8:  return a[2:0] != 3'b000;
      default: return 1'b0;
    endcase
  endfunction

  // ---------------- driver + reference model ----------------
  // Cycle 0 offers the request (and checks the buffer is idle); bus-wait
  // cycles are numbered 1..kd. addr_ok arrives in cycle ka, data_ok in kd,
  // an optional flush in kf.
  task automatic run_txn(input dbus_req_t r, input int ka, input int kd,
                         input bit hf, input int kf, input logic [63:0] bdata);
    bit flushed, timed, aok_vis;
    int pulse;
    logic [63:0] got;

    @(posedge clk); #1;
    bus.ureq       = r;
    bus.ureq.valid = 1'b1;
    bus.dresp      = '0;
    flush          = 1'b0;
    #2;
    chk("idle_busy", bus.busy, 0);
    chk("idle_dreq_valid", bus.dreq.valid, 0);
    chk("idle_data_ok", bus.uresp.data_ok, 0);
    chk("idle_misalign", bus.misalign, 0);

    if (is_misaligned(r.addr, r.size)) begin
      @(posedge clk); #1;
      bus.ureq.valid = 1'b0;
      #2;
      chk("mis_data_ok", bus.uresp.data_ok, 1);
      chk("mis_flag", bus.misalign, 1);
      chk("mis_data", bus.uresp.data, 0);
      chk("mis_timeout", bus.timeout, 0);
      chk("mis_dreq_valid", bus.dreq.valid, 0);
      chk("mis_busy", bus.busy, 1);
      return;
    end

    // Outcome from the rules: a flush no later than both data_ok and the
    // timeout cycle discards the response; otherwise a timeout strictly
    // before data_ok reports timeout; otherwise data is returned at kd.
    flushed = hf && (kf <= kd) && (T == 0 || kf <= int'(T));
    timed   = !flushed && (T != 0) && (int'(T) < kd);
    pulse   = flushed ? 0 : (timed ? int'(T) : kd);
    // addr_ok is forwarded only while still waiting for address acceptance.
    aok_vis = !(hf && kf < ka) && !(T != 0 && int'(T) < ka);

    for (int i = 1; i <= kd; i++) begin
      @(posedge clk); #1;
      bus.ureq.valid  = 1'b0;
      bus.ureq.addr   = {$urandom, $urandom};
      bus.ureq.data   = {$urandom, $urandom};
      bus.ureq.strobe = 8'($urandom);
      bus.dresp.addr_ok = (i == ka);
      bus.dresp.data_ok = (i == kd);
      bus.dresp.data    = (i == kd) ? bdata : {$urandom, $urandom};
      flush = hf && (i == kf);
      if (i == pulse) exp_q.push_back(timed ? 64'd0 : bdata);
      #2;
      chk("dreq_valid", bus.dreq.valid, 1);
      chk("dreq_addr", bus.dreq.addr, r.addr);
      chk("dreq_data", bus.dreq.data, r.data);
      chk("dreq_strobe", bus.dreq.strobe, r.strobe);
      chk("dreq_size", bus.dreq.size, r.size);
      chk("busy", bus.busy, 1);
      chk("misalign", bus.misalign, 0);
      chk("uresp_data_ok", bus.uresp.data_ok, (i == pulse));
      chk("uresp_timeout", bus.timeout, (timed && i == int'(T)));
      chk("uresp_addr_ok", bus.uresp.addr_ok, (i == ka) && aok_vis);
      if (bus.uresp.data_ok === 1'b1) begin
        chk("resp_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          got = exp_q.pop_front();
          chk("uresp_data", bus.uresp.data, got);
        end
      end
    end
  endtask

  function automatic dbus_req_t mk_req(input logic [63:0] a, input msize_t s,
                                       input logic [7:0] st, input logic [63:0] d);
    dbus_req_t r;
    r.valid  = 1'b1;
    r.addr   = a;
    r.size   = s;
    r.strobe = st;
    r.data   = d;
    return r;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    dbus_req_t r;
    int ka, kd, kf;
    bit hf;

    bus.ureq  = '0;
    bus.dresp = '0;

    // reset values
    #3;
    chk("rst_busy", bus.busy, 0);
    chk("rst_dreq_valid", bus.dreq.valid, 0);
    chk("rst_dreq_addr", bus.dreq.addr, 0);
    chk("rst_dreq_data", bus.dreq.data, 0);
    chk("rst_dreq_strobe", bus.dreq.strobe, 0);
    chk("rst_uresp", bus.uresp, 0);
    chk("rst_misalign", bus.misalign, 0);
    chk("rst_timeout", bus.timeout, 0);
    #9 reset = 1'b1;

    // aligned LD, best case
    run_txn(mk_req(64'h8000_1000, MSIZE8, 8'hFF, 64'h0), 1, 1, 0, 0, 64'hDEADBEEF_CAFEF00D);
    // SW with 3-cycle data delay
    run_txn(mk_req(64'h8000_1004, MSIZE4, 8'hF0, 64'h1234_5678_0000_0000), 1, 4, 0, 0, 64'h0);
    // flush while waiting for data: held through data_ok, no upstream pulse
    run_txn(mk_req(64'h8000_2000, MSIZE8, 8'hFF, 64'h0), 1, 5, 1, 2, 64'h5555_AAAA_5555_AAAA);
    // next request straight after the drain
    run_txn(mk_req(64'h8000_2008, MSIZE8, 8'hFF, 64'h0), 1, 2, 0, 0, 64'h0123_4567_89AB_CDEF);
    // misaligned LW
    run_txn(mk_req(64'h8000_1002, MSIZE4, 8'h0F, 64'h0), 0, 0, 0, 0, 64'h0);
    // timeout then late data_ok
    run_txn(mk_req(64'h8000_3000, MSIZE8, 8'hFF, 64'h0), 1, 10, 0, 0, 64'hFFFF_0000_FFFF_0000);
    // flush exactly in the data_ok cycle
    run_txn(mk_req(64'h8000_3010, MSIZE2, 8'h03, 64'h0), 2, 3, 1, 3, 64'h0000_0000_0000_BEEF);

    // request together with flush in IDLE is ignored
    @(posedge clk); #1;
    bus.ureq = mk_req(64'h8000_4000, MSIZE8, 8'hFF, 64'h77);
    bus.dresp = '0;
    flush = 1'b1;
    @(posedge clk); #1;
    bus.ureq.valid = 1'b0;
    flush = 1'b0;
    #2;
    chk("flush_idle_busy", bus.busy, 0);
    chk("flush_idle_dreq_valid", bus.dreq.valid, 0);

    // randomized transactions
    for (int n = 0; n < 40; n++) begin
      r = mk_req({$urandom, $urandom}, msize_t'($urandom_range(0, 3)),
                 8'($urandom), {$urandom, $urandom});
      if ($urandom_range(0, 3) != 0) r.addr[2:0] = 3'b000;
      ka = $urandom_range(1, 4);
      kd = ka + $urandom_range(0, 8);
      hf = ($urandom_range(0, 3) == 0);
      kf = $urandom_range(1, kd);
      run_txn(r, ka, kd, hf, kf, {$urandom, $urandom});
    end

    // asynchronous reset in the middle of ISSUE
    @(posedge clk); #1;
    bus.ureq = mk_req(64'h8000_5000, MSIZE8, 8'hFF, 64'h99);
    bus.dresp = '0;
    flush = 1'b0;
    @(posedge clk); #1;
    bus.ureq.valid = 1'b0;
    #2;
    chk("pre_rst_busy", bus.busy, 1);
    chk("pre_rst_dreq_valid", bus.dreq.valid, 1);
    #1 reset = 1'b0;
    #1;
    chk("arst_dreq_valid", bus.dreq.valid, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_uresp", bus.uresp, 0);
    chk("arst_dreq_addr", bus.dreq.addr, 0);
    #1 reset = 1'b1;

    // one more normal transfer after reset, then final idle check
    run_txn(mk_req(64'h8000_6000, MSIZE1, 8'h01, 64'h0), 1, 2, 0, 0, 64'h0000_0000_0000_00AB);
    @(posedge clk); #3;
    chk("end_busy", bus.busy, 0);
    chk("end_dreq_valid", bus.dreq.valid, 0);
    chk("resp_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // global time limit
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
